// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode/register encodings,
// instruction field positions, the NOP word and fetch-action encoding.
package instruction_fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 28;

    // Instruction field positions
    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;
    localparam int DST_MSB    = 23;
    localparam int DST_LSB    = 16;

    // Opcode encodings
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_STO = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_LD  = 4'h4,
        OP_JMP = 4'h8
    } opcode_e;

    // Register encodings for the destination field
    typedef enum logic [7:0] {
        REG_R0 = 8'h00,
        REG_R1 = 8'h01,
        REG_R2 = 8'h02,
        REG_R3 = 8'h03
    } reg_e;

    // All-zero word decodes as NOP
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 24'h000000};

    // What the fetch stage does on the coming edge
    typedef enum logic [1:0] {
        ACT_ISSUE    = 2'd0,
        ACT_HOLD     = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_JUMP     = 2'd3
    } fetch_action_e;

    // Opcode field of an instruction word
    function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // JMP target: destination field zero-extended to an address
    function automatic logic [ADDR_W-1:0] get_jmp_target(input logic [INSTR_W-1:0] instr);
        return {8'h00, instr[DST_MSB:DST_LSB]};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage, its program ROM and the decode stage.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 28
);
    logic [ADDR_W-1:0]  oRomAddress;
    logic [INSTR_W-1:0] iRomInstruction;
    logic               iStall;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic [INSTR_W-1:0] oInstruction;
    logic               oInstrValid;
    logic [ADDR_W-1:0]  oInstrPC;
    logic [15:0]        oFetchCount;

    modport master (
        output oRomAddress, oInstruction, oInstrValid, oInstrPC, oFetchCount,
        input  iRomInstruction, iStall, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oRomAddress, oInstruction, oInstrValid, oInstrPC, oFetchCount,
        output iRomInstruction, iStall, iBranchTaken, iBranchTarget
    );
endinterface

// File: rtl/instruction_fetch_pc_next_logic.sv
// Combinational next-PC selector: redirect > stall > JMP > sequential.
module pc_next_logic
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              jmp_detect,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] next_pc,
    output fetch_action_e     action
);

    // Priority mux choosing the next PC and the action for the IR side
    always_comb begin
        next_pc = pc;
        action  = ACT_HOLD;
        if (redirect) begin
            next_pc = redirect_target;
            action  = ACT_REDIRECT;
        end else if (stall) begin
            next_pc = pc;
            action  = ACT_HOLD;
        end else if (jmp_detect) begin
            next_pc = jmp_target;
            action  = ACT_JUMP;
        end else begin
            next_pc = pc + ADDR_W'(1);
            action  = ACT_ISSUE;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register drives the ROM, fetched word is registered into
// the IR. Unconditional JMPs are resolved here and never issued downstream.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    instruction_fetch_if.master  bus
);

    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] ir_r;
    logic               valid_r;
    logic [ADDR_W-1:0]  instr_pc_r;
    logic [15:0]        count_r;

    logic [ADDR_W-1:0]  next_pc_s;
    fetch_action_e      action_s;
    logic               jmp_s;
    logic [ADDR_W-1:0]  jmp_target_s;

    assign jmp_s        = (get_opcode(bus.iRomInstruction) == OP_JMP);
    assign jmp_target_s = ADDR_W'(bus.iRomInstruction[DST_MSB:DST_LSB]);

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc              (pc_r),
        .stall           (bus.iStall),
        .redirect        (bus.iBranchTaken),
        .redirect_target (bus.iBranchTarget),
        .jmp_detect      (jmp_s),
        .jmp_target      (jmp_target_s),
        .next_pc         (next_pc_s),
        .action          (action_s)
    );

    // PC, IR, valid, issue PC and fetch counter update
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_r       <= RESET_PC;
            ir_r       <= NOP_INSTR;
            valid_r    <= 1'b0;
            instr_pc_r <= {ADDR_W{1'b0}};
            count_r    <= 16'd0;
        end else begin
            pc_r <= next_pc_s;
            case (action_s)
                ACT_REDIRECT: begin
                    valid_r <= 1'b0;
                end
                ACT_HOLD: begin
                    valid_r <= valid_r;
                end
                ACT_JUMP: begin
                    valid_r    <= 1'b0;
                    instr_pc_r <= pc_r;
                end
                ACT_ISSUE: begin
                    ir_r       <= bus.iRomInstruction;
                    instr_pc_r <= pc_r;
                    valid_r    <= 1'b1;
                    count_r    <= count_r + 16'd1;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oRomAddress  = pc_r;
    assign bus.oInstruction = ir_r;
    assign bus.oInstrValid  = valid_r;
    assign bus.oInstrPC     = instr_pc_r;
    assign bus.oFetchCount  = count_r;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that drives the program ROM's 16-bit address and registers the 28-bit instruction it returns into an instruction register (IR) for the decode/execute stage.
- Resolves unconditional JMP locally.
- Accepts a taken-branch redirect and a stall from downstream.
- Presents a valid-qualified IR together with the PC it was fetched from.

Parameters:
ADDR_W, 16, program counter / ROM address width
INSTR_W, 28, instruction width
RESET_PC, 16'd0, PC value loaded on reset

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
oRomAddress  output  ADDR_W  address to ROM; equals PC register (combinational from PC)
iRomInstruction  input  INSTR_W  ROM data for oRomAddress (combinational ROM, same cycle)
iStall  input  1  downstream cannot accept; hold PC and IR
iBranchTaken  input  1  downstream resolved a taken branch; redirect and flush
iBranchTarget  input  ADDR_W  redirect address, sampled when iBranchTaken=1
oInstruction  output  INSTR_W  IR contents
oInstrValid  output  1  IR holds a real instruction
oInstrPC  output  ADDR_W  address the IR was fetched from
oFetchCount  output  16  number of instructions loaded into IR with valid=1, wraps

Behaviour:
- Field layout:
  - [27:24] opcode.
  - [23:16] destination, or JMP target.
  - [15:0] operands / immediate.
  - JMP target address is {8'b0, [23:16]}.
- Reset (async, any time, including mid-stall):
  - PC=RESET_PC, oInstruction=NOP encoding, oInstrValid=0, oInstrPC=0, oFetchCount=0.
  - Outputs are valid immediately on Reset assertion.
- Latency: one cycle from ROM data to IR. The instruction at address A appears on oInstruction the edge after PC=A.
- Per-edge priority, highest first:
  1. iBranchTaken=1: PC<=iBranchTarget; oInstrValid<=0 (flush); IR content don't-care; counter unchanged. Overrides iStall.
  2. iStall=1: PC, IR, oInstrValid, oInstrPC, counter all hold.
  3. Fetched opcode == JMP: PC<=JMP target; oInstrValid<=0 (JMP is consumed and never issued downstream); oInstrPC<=PC; counter unchanged.
  4. Otherwise:
     - IR<=iRomInstruction, oInstrPC<=PC, oInstrValid<=1.
     - PC<=PC+1, modulo 2^ADDR_W; 16'hFFFF wraps to 0.
     - counter+=1, wraps from 16'hFFFF to 0.
- JMP to its own address: PC stays constant; oInstrValid remains 0 every cycle. This is the legal halt idiom.
- JMP followed by JMP: each costs one bubble cycle; no instruction is skipped or issued twice.
- Branch redirect to an address holding a JMP: that JMP is resolved on the next cycle as in rule 3.
- No combinational path from iStall or iBranchTaken to oRomAddress. oRomAddress depends only on the PC register.
- Opcode values are not duplicated here. JMP, NOP and the other opcodes come from the shared definitions header.

Decomposition:
- Shared definitions header already holds the opcode and register encodings and must also hold:
  - Field position constants: OPCODE_MSB/LSB, DST_MSB/LSB.
  - The NOP instruction constant.
- New module: one sub-module, pc_next_logic.
  - Combinational next-PC selector.
  - Inputs: PC, stall, redirect, JMP detect.
  - Separates the priority mux from the registers and allows isolated unit testing.

Test Plan:
1. Reset, then run from ROM containing STO,STO,STO,ADD at 0..3.
   -> Edges 1-4: oInstrPC=0,1,2,3; oInstrValid=1; oFetchCount=4.
2. JMP 8'd5 at address 4, NOP at 5.
   -> Cycle after fetching 4: oInstrValid=0 and PC=5. Next edge: oInstrPC=5, valid=1. Counter does not count the JMP.
3. iStall held 3 cycles while IR holds address 2.
   -> oInstruction, oInstrPC=2 and oRomAddress=3 are unchanged for all 3 cycles; then resume at 3.
4. iBranchTaken=1 with target 16'h0040 while iStall=1.
   -> Redirect wins: next edge PC=16'h0040, oInstrValid=0. Following edge oInstrPC=16'h0040.
5. Redirect to 16'hFFFF holding a non-JMP instruction.
   -> oInstrPC=16'hFFFF, then PC wraps to 0 and the next issued oInstrPC=0.
6. Reset asserted asynchronously between clock edges mid-stream.
   -> oInstrValid=0, oRomAddress=0 and oFetchCount=0 without waiting for a clock edge. Fetch restarts at 0 after release.
